// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format (data bits, parity, stop bits)
// feeding a first-word-fall-through receive FIFO with sticky error flags.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun_err,
    output logic [2:0]                    rx_state
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Expected parity bit: XOR of the data, inverted for odd parity.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY == 1);
    endfunction

    state_t                state_r;
    logic [TW-1:0]         timer_r;
    logic [BW-1:0]         bit_cnt_r;
    logic                  stop_cnt_r;
    logic [DATA_BITS-1:0]  shift_r;
    logic                  par_bad_r, frm_bad_r;
    logic                  commit_r, commit_frm_r, commit_par_r;
    logic                  rx_meta_r, rx_sync_r, rx_prev_r;
    logic                  sample_s;

    logic [DATA_BITS-1:0]  mem_r [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]         count_r, count_nxt_s;
    logic                  empty_r, full_r;
    logic [DATA_BITS-1:0]  rd_data_r;
    logic                  parity_err_r, frame_err_r, overrun_err_r;
    logic                  pop_s, good_s, push_s, set_frm_s, set_par_s, set_ovr_s;

    assign sample_s = (timer_r == TW'(CLKS_PER_BIT - 1));

    // Synchronizer, bit timer and deframing state machine.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            timer_r      <= '0;
            bit_cnt_r    <= '0;
            stop_cnt_r   <= 1'b0;
            shift_r      <= '0;
            par_bad_r    <= 1'b0;
            frm_bad_r    <= 1'b0;
            commit_r     <= 1'b0;
            commit_frm_r <= 1'b0;
            commit_par_r <= 1'b0;
            rx_meta_r    <= 1'b1;
            rx_sync_r    <= 1'b1;
            rx_prev_r    <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
            commit_r  <= 1'b0;
            if (state_r != ST_IDLE) begin
                timer_r <= sample_s ? '0 : timer_r + 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (rx_prev_r && !rx_sync_r) begin
                        // Preload so the first sample lands half a bit after the edge.
                        state_r    <= ST_START;
                        timer_r    <= TW'(CLKS_PER_BIT - CLKS_PER_BIT / 2);
                        bit_cnt_r  <= '0;
                        stop_cnt_r <= 1'b0;
                        par_bad_r  <= 1'b0;
                        frm_bad_r  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (sample_s) begin
                        state_r <= rx_sync_r ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sample_s) begin
                        shift_r <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == BW'(DATA_BITS - 1)) begin
                            state_r <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample_s) begin
                        par_bad_r <= (rx_sync_r != calc_parity(shift_r));
                        state_r   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (sample_s) begin
                        if (stop_cnt_r == 1'(STOP_BITS - 1)) begin
                            state_r      <= ST_IDLE;
                            commit_r     <= 1'b1;
                            commit_frm_r <= frm_bad_r | ~rx_sync_r;
                            commit_par_r <= par_bad_r;
                        end else begin
                            stop_cnt_r <= 1'b1;
                            frm_bad_r  <= frm_bad_r | ~rx_sync_r;
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Commit decision and FIFO occupancy arithmetic.
    always_comb begin
        pop_s     = rd_en & ~empty_r;
        good_s    = commit_r & ~commit_frm_r & ~commit_par_r;
        push_s    = good_s & (~full_r | pop_s);
        set_frm_s = commit_r & commit_frm_r;
        set_par_s = commit_r & ~commit_frm_r & commit_par_r;
        set_ovr_s = good_s & full_r & ~pop_s;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 1'b1;
            2'b01:   count_nxt_s = count_r - 1'b1;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers, status and registered head word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            rd_data_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == CW'(0));
            full_r  <= (count_nxt_s == CW'(FIFO_DEPTH));
            // A word pushed into an (effectively) empty FIFO bypasses storage.
            if (push_s && (empty_r || (pop_s && count_r == CW'(1)))) begin
                rd_data_r <= shift_r;
            end else if (pop_s) begin
                rd_data_r <= mem_r[rd_ptr_r + 1'b1];
            end
        end
    end

    // Sticky error flags; a set event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            parity_err_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            overrun_err_r <= 1'b0;
        end else begin
            parity_err_r  <= set_par_s | (parity_err_r & ~err_clr);
            frame_err_r   <= set_frm_s | (frame_err_r & ~err_clr);
            overrun_err_r <= set_ovr_s | (overrun_err_r & ~err_clr);
        end
    end

    assign rd_data     = rd_data_r;
    assign empty       = empty_r;
    assign full        = full_r;
    assign count       = count_r;
    assign parity_err  = parity_err_r;
    assign frame_err   = frame_err_r;
    assign overrun_err = overrun_err_r;
    assign rx_state    = state_r;

endmodule
